// File: rtl/cpu_pkg.sv
// Shared RV32I pipeline definitions: reset/bubble constants, fetch FSM states and the
// PC/instruction packet used by the fetch stage.
package cpu_pkg;

  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;  // addi x0,x0,0

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    DRAIN = 2'd2
  } fetch_state_t;

  // Selects the next fetch address.
  typedef enum logic [2:0] {
    PC_KEEP     = 3'd0,
    PC_INC      = 3'd1,
    PC_SKID_INC = 3'd2,
    PC_TARGET   = 3'd3,
    PC_PEND     = 3'd4
  } pc_sel_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_pkt_t;

endpackage

// File: rtl/pc_gen.sv
// Next fetch-address mux with a single shared +4 adder; also word-aligns redirect targets.
module pc_gen
  import cpu_pkg::*;
(
  input  pc_sel_t     sel_i,
  input  logic [31:0] req_pc_i,
  input  logic [31:0] skid_pc_i,
  input  logic [31:0] pend_pc_i,
  input  logic [31:0] redirect_pc_i,
  output logic [31:0] target_o,
  output logic [31:0] next_pc_o
);

  logic [31:0] inc_base;
  logic [31:0] inc_pc;

  always_comb begin
    target_o = {redirect_pc_i[31:2], 2'b00};
    inc_base = (sel_i == PC_SKID_INC) ? skid_pc_i : req_pc_i;
    inc_pc   = inc_base + 32'd4;  // wraps naturally at 2^32

    case (sel_i)
      PC_INC, PC_SKID_INC: next_pc_o = inc_pc;
      PC_TARGET:           next_pc_o = target_o;
      PC_PEND:             next_pc_o = pend_pc_i;
      default:             next_pc_o = req_pc_i;
    endcase
  end

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the fetch PC, runs the req/ack handshake to instruction
// memory, parks fetched words in a skid buffer under stall, and registers IF/ID.
module if_fetch_stage
  import cpu_pkg::fetch_state_t;
  import cpu_pkg::fetch_pkt_t;
  import cpu_pkg::pc_sel_t;
  import cpu_pkg::FETCH;
  import cpu_pkg::HOLD;
  import cpu_pkg::DRAIN;
  import cpu_pkg::PC_KEEP;
  import cpu_pkg::PC_INC;
  import cpu_pkg::PC_SKID_INC;
  import cpu_pkg::PC_TARGET;
  import cpu_pkg::PC_PEND;
#(
  parameter logic [31:0] RESET_PC  = cpu_pkg::RESET_PC,
  parameter logic [31:0] NOP_INSTR = cpu_pkg::NOP_INSTR
) (
  input  logic        clk,
  input  logic        rst,
  output logic        im_req,
  output logic [31:0] im_addr,
  input  logic        im_ack,
  input  logic [31:0] im_rdata,
  input  logic        pipe_stall,
  input  logic        pc_redirect,
  input  logic [31:0] redirect_pc,
  output logic        im_stall,
  output logic [31:0] IF_PC_out,
  output logic [31:0] IF_Instraction_out,
  output logic        IF_valid
);

  fetch_state_t state_q, state_d;
  logic [31:0]  req_pc_q, req_pc_d;
  logic [31:0]  pend_pc_q, pend_pc_d;
  fetch_pkt_t   skid_q, skid_d;
  fetch_pkt_t   ifid_q, ifid_d;
  logic         valid_q, valid_d;
  pc_sel_t      pc_sel;
  logic [31:0]  target;

  pc_gen u_pc_gen (
    .sel_i         (pc_sel),
    .req_pc_i      (req_pc_q),
    .skid_pc_i     (skid_q.pc),
    .pend_pc_i     (pend_pc_q),
    .redirect_pc_i (redirect_pc),
    .target_o      (target),
    .next_pc_o     (req_pc_d)
  );

  always_comb begin
    state_d   = state_q;
    pend_pc_d = pend_pc_q;
    skid_d    = skid_q;
    ifid_d    = ifid_q;
    valid_d   = valid_q;
    pc_sel    = PC_KEEP;

    // A redirect always flushes IF/ID, regardless of stall or state.
    if (pc_redirect) begin
      ifid_d.instr = NOP_INSTR;
      valid_d      = 1'b0;
    end

    case (state_q)
      FETCH: begin
        if (pc_redirect) begin
          if (im_ack) begin
            pc_sel = PC_TARGET;
          end else begin
            // Address must stay stable until the outstanding ack, so park the target.
            pend_pc_d = target;
            state_d   = DRAIN;
          end
        end else if (im_ack) begin
          if (pipe_stall) begin
            skid_d.pc    = req_pc_q;
            skid_d.instr = im_rdata;
            state_d      = HOLD;
          end else begin
            ifid_d.pc    = req_pc_q;
            ifid_d.instr = im_rdata;
            valid_d      = 1'b1;
            pc_sel       = PC_INC;
          end
        end else if (!pipe_stall) begin
          ifid_d.instr = NOP_INSTR;
          valid_d      = 1'b0;
        end
      end
      HOLD: begin
        if (pc_redirect) begin
          pc_sel  = PC_TARGET;
          state_d = FETCH;
        end else if (!pipe_stall) begin
          ifid_d  = skid_q;
          valid_d = 1'b1;
          pc_sel  = PC_SKID_INC;
          state_d = FETCH;
        end
      end
      DRAIN: begin
        if (pc_redirect) begin
          pend_pc_d = target;
        end
        if (im_ack) begin
          pc_sel  = pc_redirect ? PC_TARGET : PC_PEND;
          state_d = FETCH;
        end
      end
      default: state_d = FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= FETCH;
      req_pc_q  <= RESET_PC;
      pend_pc_q <= RESET_PC;
      skid_q    <= '0;
      ifid_q    <= '{pc: 32'h0, instr: NOP_INSTR};
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      req_pc_q  <= req_pc_d;
      pend_pc_q <= pend_pc_d;
      skid_q    <= skid_d;
      ifid_q    <= ifid_d;
      valid_q   <= valid_d;
    end
  end

  always_comb begin
    im_req             = ~rst & ((state_q == FETCH) | (state_q == DRAIN));
    im_addr            = req_pc_q;
    im_stall           = ((state_q == FETCH) & ~im_ack) | (state_q == DRAIN);
    IF_PC_out          = ifid_q.pc;
    IF_Instraction_out = ifid_q.instr;
    IF_valid           = valid_q;
  end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage: bench drives the memory ack, expected IF/ID packets are
// queued when a delivering step is driven and checked on the following clock.
module tb_if_fetch_stage;
  import cpu_pkg::*;

  logic        clk;
  logic        rst;
  logic        im_req;
  logic [31:0] im_addr;
  logic        im_ack;
  logic [31:0] im_rdata;
  logic        pipe_stall;
  logic        pc_redirect;
  logic [31:0] redirect_pc;
  logic        im_stall;
  logic [31:0] IF_PC_out;
  logic [31:0] IF_Instraction_out;
  logic        IF_valid;

  int checks;
  int failures;
  fetch_pkt_t exp_q[$];

  if_fetch_stage dut (
    .clk                (clk),
    .rst                (rst),
    .im_req             (im_req),
    .im_addr            (im_addr),
    .im_ack             (im_ack),
    .im_rdata           (im_rdata),
    .pipe_stall         (pipe_stall),
    .pc_redirect        (pc_redirect),
    .redirect_pc        (redirect_pc),
    .im_stall           (im_stall),
    .IF_PC_out          (IF_PC_out),
    .IF_Instraction_out (IF_Instraction_out),
    .IF_valid           (IF_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic [31:0] pc);
    fetch_pkt_t p;
    p.pc    = pc;
    p.instr = pc ^ 32'hA5;
    exp_q.push_back(p);
  endtask

  // One clock: drive inputs after a negedge, check handshake outputs, then IF/ID after posedge.
  task automatic step(input string tag, input logic ack, input logic stall, input logic redir,
                      input logic [31:0] rpc, input logic exp_req, input logic [31:0] exp_addr,
                      input logic exp_stall, input logic exp_valid);
    fetch_pkt_t p;
    im_ack      = ack;
    pipe_stall  = stall;
    pc_redirect = redir;
    redirect_pc = rpc;
    im_rdata    = exp_addr ^ 32'hA5;
    #1;
    chk({tag, ".im_req"}, {31'b0, im_req}, {31'b0, exp_req});
    if (exp_req) chk({tag, ".im_addr"}, im_addr, exp_addr);
    chk({tag, ".im_stall"}, {31'b0, im_stall}, {31'b0, exp_stall});
    @(posedge clk);
    #1;
    chk({tag, ".valid"}, {31'b0, IF_valid}, {31'b0, exp_valid});
    if (exp_q.size() != 0) begin
      p = exp_q.pop_front();
      chk({tag, ".if_pc"}, IF_PC_out, p.pc);
      chk({tag, ".if_instr"}, IF_Instraction_out, p.instr);
    end
    @(negedge clk);
  endtask

  initial begin
    checks      = 0;
    failures    = 0;
    rst         = 1'b1;
    im_ack      = 1'b0;
    im_rdata    = '0;
    pipe_stall  = 1'b0;
    pc_redirect = 1'b0;
    redirect_pc = '0;
    #2;
    chk("rst.im_req", {31'b0, im_req}, 32'd0);
    chk("rst.valid", {31'b0, IF_valid}, 32'd0);
    chk("rst.if_pc", IF_PC_out, 32'h0);
    chk("rst.if_instr", IF_Instraction_out, NOP_INSTR);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Zero-wait memory: one instruction per cycle.
    for (int a = 0; a < 16; a += 4) begin
      push_exp(a);
      step("zw", 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, a, 1'b0, 1'b1);
    end

    // Three-cycle latency at 0x10.
    step("lat0", 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h10, 1'b1, 1'b0);
    chk("lat0.nop", IF_Instraction_out, NOP_INSTR);
    step("lat1", 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h10, 1'b1, 1'b0);
    push_exp(32'h10);
    step("lat2", 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h10, 1'b0, 1'b1);
    for (int a = 32'h14; a < 32'h20; a += 4) begin
      push_exp(a);
      step("zw2", 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, a, 1'b0, 1'b1);
    end

    // Ack at 0x20 under a 4-cycle stall: parked in the skid buffer.
    step("stall_ack", 1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'h20, 1'b0, 1'b1);
    chk("stall_ack.held_pc", IF_PC_out, 32'h1C);
    for (int i = 0; i < 3; i++) begin
      step("hold", 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h20, 1'b0, 1'b1);
      chk("hold.held_pc", IF_PC_out, 32'h1C);
    end
    push_exp(32'h20);
    step("release", 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h20, 1'b0, 1'b1);
    for (int a = 32'h24; a < 32'h40; a += 4) begin
      push_exp(a);
      step("zw3", 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, a, 1'b0, 1'b1);
    end

    // Redirect to 0x103 while 0x40 is outstanding; stale ack two cycles later.
    step("redir", 1'b0, 1'b0, 1'b1, 32'h103, 1'b1, 32'h40, 1'b1, 1'b0);
    step("drain0", 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h40, 1'b1, 1'b0);
    step("drain1", 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h40, 1'b1, 1'b0);
    step("tgt_wait", 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h100, 1'b1, 1'b0);
    push_exp(32'h100);
    step("tgt", 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h100, 1'b0, 1'b1);

    // Redirect beats stall in the same cycle as an ack.
    step("redir_stall", 1'b1, 1'b1, 1'b1, 32'h200, 1'b1, 32'h104, 1'b0, 1'b0);
    chk("redir_stall.nop", IF_Instraction_out, NOP_INSTR);
    push_exp(32'h200);
    step("tgt200", 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h200, 1'b0, 1'b1);

    // Async reset while draining.
    step("to_drain", 1'b0, 1'b0, 1'b1, 32'h300, 1'b1, 32'h204, 1'b1, 1'b0);
    chk("to_drain.bubble_pc", IF_PC_out, 32'h200);
    im_ack      = 1'b0;
    pc_redirect = 1'b0;
    rst         = 1'b1;
    #1;
    chk("arst.im_req", {31'b0, im_req}, 32'd0);
    chk("arst.if_pc", IF_PC_out, 32'h0);
    chk("arst.if_instr", IF_Instraction_out, NOP_INSTR);
    chk("arst.valid", {31'b0, IF_valid}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    push_exp(RESET_PC);
    step("post_rst", 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, RESET_PC, 1'b0, 1'b1);

    // Address wrap at the top of memory.
    step("redir_wrap", 1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1, 32'h4, 1'b0, 1'b0);
    push_exp(32'hFFFF_FFFC);
    step("top", 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'hFFFF_FFFC, 1'b0, 1'b1);
    push_exp(32'h0);
    step("wrap", 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0, 1'b0, 1'b1);

    chk("sb_empty", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
